// File: rtl/shf_arbiter.sv
// Two-requester arbiter sharing one shifter: issues one operation per 3 cycles and captures tagged results.
// Build option: define SHF_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module shf_arbiter #(
    parameter int unsigned DATASIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [1:0]          cls0,
    input  logic [1:0]          cls1,
    input  logic [DATASIZE-1:0] rx0,
    input  logic [DATASIZE-1:0] rx1,
    input  logic [DATASIZE-1:0] ry0,
    input  logic [DATASIZE-1:0] ry1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                busy,
    output logic                shf_en,
    output logic [1:0]          shf_cls,
    output logic [DATASIZE-1:0] shf_rx,
    output logic [DATASIZE-1:0] shf_ry,
    input  logic [DATASIZE-1:0] shf_rn,
    input  logic                shf_ov,
    input  logic                shf_z,
    output logic                done,
    output logic                done_id,
    output logic [DATASIZE-1:0] rn,
    output logic                ovflag,
    output logic                zflag,
    output logic                ov_sticky,
    input  logic                ov_clr
);

    localparam int unsigned CLS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_shf_en;
    logic [CLS_W-1:0]      r_shf_cls;
    logic [DATASIZE-1:0]   r_shf_rx;
    logic [DATASIZE-1:0]   r_shf_ry;
    logic                  r_id;
    logic                  r_done;
    logic                  r_done_id;
    logic [DATASIZE-1:0]   r_rn;
    logic                  r_ovflag;
    logic                  r_zflag;
    logic                  r_ov_sticky;

    logic                  w_avail;
    logic                  w_pick1;
    logic                  w_grant;

`ifdef SHF_ARB_RR_EN
    logic                  r_prefer1;

    // Round-robin pointer: after a grant, the other requester is favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefer1 <= 1'b0;
        end else if (w_grant) begin
            r_prefer1 <= ~w_pick1;
        end
    end
`endif

    // Grants are only offered from IDLE and never while reset is held.
    always_comb begin
        w_avail = rst_n && (r_state == ST_IDLE);
`ifdef SHF_ARB_RR_EN
        w_pick1 = req1 && (!req0 || r_prefer1);
`else
        w_pick1 = req1 && !req0;
`endif
        gnt0    = w_avail && req0 && !w_pick1;
        gnt1    = w_avail && w_pick1;
        w_grant = gnt0 || gnt1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_shf_en    <= 1'b0;
            r_shf_cls   <= '0;
            r_shf_rx    <= '0;
            r_shf_ry    <= '0;
            r_id        <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 1'b0;
            r_rn        <= '0;
            r_ovflag    <= 1'b0;
            r_zflag     <= 1'b0;
            r_ov_sticky <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ov_clr) begin
                r_ov_sticky <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_shf_cls <= w_pick1 ? cls1 : cls0;
                        r_shf_rx  <= w_pick1 ? rx1 : rx0;
                        r_shf_ry  <= w_pick1 ? ry1 : ry0;
                        r_id      <= w_pick1;
                        r_shf_en  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_shf_en <= 1'b0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A capture in the same cycle as ov_clr leaves only this op's overflow.
                    r_rn        <= shf_rn;
                    r_ovflag    <= shf_ov;
                    r_zflag     <= shf_z;
                    r_done_id   <= r_id;
                    r_done      <= 1'b1;
                    r_ov_sticky <= shf_ov | (r_ov_sticky & ~ov_clr);
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_shf_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign shf_en    = r_shf_en;
    assign shf_cls   = r_shf_cls;
    assign shf_rx    = r_shf_rx;
    assign shf_ry    = r_shf_ry;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign rn        = r_rn;
    assign ovflag    = r_ovflag;
    assign zflag     = r_zflag;
    assign ov_sticky = r_ov_sticky;

endmodule

// File: tb/tb_shf_arbiter.sv
// Self-checking bench for shf_arbiter: behavioural shifter stub, cycle-scheduled model, directed ops.
module tb_shf_arbiter;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [1:0]    cls0, cls1;
    logic [DW-1:0] rx0, rx1, ry0, ry1;
    logic          gnt0, gnt1, busy, shf_en;
    logic [1:0]    shf_cls;
    logic [DW-1:0] shf_rx, shf_ry, shf_rn;
    logic          shf_ov, shf_z;
    logic          done, done_id;
    logic [DW-1:0] rn;
    logic          ovflag, zflag, ov_sticky, ov_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shf_arbiter #(.DATASIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .cls0(cls0), .cls1(cls1),
        .rx0(rx0), .rx1(rx1), .ry0(ry0), .ry1(ry1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .shf_en(shf_en), .shf_cls(shf_cls), .shf_rx(shf_rx), .shf_ry(shf_ry),
        .shf_rn(shf_rn), .shf_ov(shf_ov), .shf_z(shf_z),
        .done(done), .done_id(done_id), .rn(rn),
        .ovflag(ovflag), .zflag(zflag), .ov_sticky(ov_sticky), .ov_clr(ov_clr)
    );

    // Shifter behaviour: returns {ov, zero, result}.
    function automatic logic [17:0] shf_f(input logic [1:0] c, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic        ov;
        int          n;
        int          k;
        r  = '0;
        ov = 1'b0;
        case (c)
            2'b00: begin
                n = int'($signed(y));
                if (n >= 16) begin
                    r  = '0;
                    ov = (x != '0);
                end else if (n >= 0) begin
                    r  = x << n;
                    ov = (($signed(r) >>> n) != $signed(x));
                end else if (n <= -16) begin
                    r = {16{x[15]}};
                end else begin
                    r = 16'($signed(x) >>> (-n));
                end
            end
            2'b01: begin
                k = int'(y[3:0]);
                r = (x << k) | (x >> (16 - k));
            end
            2'b10: begin
                r = 16'd16;
                for (int i = 0; i < 16; i++) if (x[i]) r = 16'(15 - i);
                ov = (x == '0);
            end
            default: begin
                r = 16'd16;
                for (int i = 0; i < 16; i++) if (!x[i]) r = 16'(15 - i);
                ov = (x == '1);
            end
        endcase
        return {ov, (r == '0), r};
    endfunction

    // Shifter stub: latches operands on the enable edge, output stable afterwards.
    logic [1:0]  s_cls = '0;
    logic [15:0] s_rx = '0, s_ry = '0;
    logic [17:0] s_out;
    always @(posedge clk) begin
        if (shf_en) begin
            s_cls <= shf_cls;
            s_rx  <= shf_rx;
            s_ry  <= shf_ry;
        end
    end
    assign s_out  = shf_f(s_cls, s_rx, s_ry);
    assign shf_rn = s_out[15:0];
    assign shf_z  = s_out[16];
    assign shf_ov = s_out[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each grant at cycle g schedules shf_en at g+1, busy at g+1..g+2, done/results at g+3.
    int          cyc = 0;
    int          last_g = 0;
    bit          have_g = 0;
    logic [1:0]  m_cls;
    logic [15:0] m_rx, m_ry, m_rn;
    logic        m_id, m_ov, m_z, m_did, m_sticky;
`ifdef SHF_ARB_RR_EN
    logic        m_prefer1;
`endif
    bit          p_gnt = 0;
    logic        p_win, p_clr;
    logic [1:0]  p_cls;
    logic [15:0] p_rx, p_ry;

    always @(negedge clk) begin
        logic [17:0] res;
        bit free, w1, eg0, eg1, ebusy, een, edone;
        cyc++;
        if (!rst_n) begin
            have_g = 0; p_gnt = 0; p_clr = 1'b0;
            m_cls = '0; m_rx = '0; m_ry = '0; m_id = 1'b0;
            m_rn = '0; m_ov = 1'b0; m_z = 1'b0; m_did = 1'b0; m_sticky = 1'b0;
`ifdef SHF_ARB_RR_EN
            m_prefer1 = 1'b0;
`endif
        end else begin
            if (have_g && (cyc - 1 == last_g + 2)) begin
                res      = shf_f(m_cls, m_rx, m_ry);
                m_rn     = res[15:0];
                m_z      = res[16];
                m_ov     = res[17];
                m_did    = m_id;
                m_sticky = res[17] | (m_sticky & ~p_clr);
            end else if (p_clr) begin
                m_sticky = 1'b0;
            end
            if (p_gnt) begin
                have_g = 1; last_g = cyc - 1;
                m_cls = p_cls; m_rx = p_rx; m_ry = p_ry; m_id = p_win;
`ifdef SHF_ARB_RR_EN
                m_prefer1 = ~p_win;
`endif
            end
        end
        free = rst_n && (!have_g || cyc >= last_g + 3);
`ifdef SHF_ARB_RR_EN
        w1 = req1 && (!req0 || m_prefer1);
`else
        w1 = req1 && !req0;
`endif
        eg0   = free && req0 && !w1;
        eg1   = free && w1;
        ebusy = have_g && (cyc == last_g + 1 || cyc == last_g + 2);
        een   = have_g && (cyc == last_g + 1);
        edone = have_g && (cyc == last_g + 3);
        check("gnt0", 32'(gnt0), 32'(eg0));
        check("gnt1", 32'(gnt1), 32'(eg1));
        check("busy", 32'(busy), 32'(ebusy));
        check("shf_en", 32'(shf_en), 32'(een));
        check("done", 32'(done), 32'(edone));
        check("shf_cls", 32'(shf_cls), 32'(m_cls));
        check("shf_rx", 32'(shf_rx), 32'(m_rx));
        check("shf_ry", 32'(shf_ry), 32'(m_ry));
        check("rn", 32'(rn), 32'(m_rn));
        check("ovflag", 32'(ovflag), 32'(m_ov));
        check("zflag", 32'(zflag), 32'(m_z));
        check("done_id", 32'(done_id), 32'(m_did));
        check("ov_sticky", 32'(ov_sticky), 32'(m_sticky));
        p_gnt = eg0 || eg1;
        p_win = w1;
        p_cls = w1 ? cls1 : cls0;
        p_rx  = w1 ? rx1 : rx0;
        p_ry  = w1 ? ry1 : ry0;
        p_clr = rst_n && ov_clr;
    end

    // Issue one op from a single requester; returns at the done cycle with gnt-to-done latency.
    task automatic run_op(input bit id, input logic [1:0] c, input logic [15:0] x, input logic [15:0] y,
                          output int lat);
        bit  ok;
        time t0;
        lat = -1;
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; cls1 = c; rx1 = x; ry1 = y; end
        else    begin req0 = 1'b1; cls0 = c; rx0 = x; ry0 = y; end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) ok = 1;
        end
        check("gnt_wait", 32'(ok), 32'd1);
        t0 = $time;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        check("done_wait", 32'(ok), 32'd1);
        lat = int'(($time - t0) / 10);
    endtask

    initial begin
        int  lat;
        int  n;
        time tg;
        logic [3:0] order;
        logic [3:0] exp_order;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; ov_clr = 1'b0;
        cls0 = '0; cls1 = '0; rx0 = '0; rx1 = '0; ry0 = '0; ry1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1'b0, 2'b00, 16'hF000, 16'hFFFC, lat);
        check("single_lat", 32'(lat), 32'd3);
        check("single_rn", 32'(rn), 32'hFF00);
        check("single_ov", 32'(ovflag), 32'd0);
        check("single_z", 32'(zflag), 32'd0);
        check("single_id", 32'(done_id), 32'd0);

        run_op(1'b1, 2'b00, 16'h4000, 16'h0001, lat);
        check("ovf_rn", 32'(rn), 32'h8000);
        check("ovf_ov", 32'(ovflag), 32'd1);
        check("ovf_sticky", 32'(ov_sticky), 32'd1);
        check("ovf_id", 32'(done_id), 32'd1);
        run_op(1'b1, 2'b00, 16'h0001, 16'h0001, lat);
        check("noovf_ov", 32'(ovflag), 32'd0);
        check("noovf_sticky", 32'(ov_sticky), 32'd1);

        // Contention: both requests held for four grants.
        @(posedge clk); #1;
        req0 = 1'b1; cls0 = 2'b00; rx0 = 16'h0003; ry0 = 16'h0002;
        req1 = 1'b1; cls1 = 2'b01; rx1 = 16'h8000; ry1 = 16'h0001;
        n = 0; order = '0; tg = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (n > 0) begin
                    check("b2b_done_with_gnt", 32'(done), 32'd1);
                    check("b2b_interval", 32'($time - tg), 32'd30);
                end
                tg = $time;
                order[n] = gnt1;
                n++;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
`ifdef SHF_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        check("contention_count", 32'(n), 32'd4);
        check("contention_order", 32'(order), 32'(exp_order));
        repeat (4) @(negedge clk);

        @(posedge clk); #1 ov_clr = 1'b1;
        @(posedge clk); #1 ov_clr = 1'b0;
        @(negedge clk);
        check("clr_sticky", 32'(ov_sticky), 32'd0);

        run_op(1'b0, 2'b10, 16'h0000, 16'hFFFF, lat);
        check("lz0_rn", 32'(rn), 32'h0010);
        check("lz0_ov", 32'(ovflag), 32'd1);
        check("lz0_z", 32'(zflag), 32'd0);
        run_op(1'b0, 2'b10, 16'h00F0, 16'hFFFF, lat);
        check("lz8_rn", 32'(rn), 32'h0008);

        // Reset while in WAIT, then check the pointer returned to req0.
        @(posedge clk); #1;
        req0 = 1'b1; cls0 = 2'b00; rx0 = 16'h0003; ry0 = 16'h0001;
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            @(negedge clk);
            if (gnt0) n = 1;
        end
        check("rst_gnt_wait", 32'(n), 32'd1);
        @(posedge clk); #1 req0 = 1'b0;
        @(posedge clk); #1;
        check("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_shf_en", 32'(shf_en), 32'd0);
        check("rst_rn", 32'(rn), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("post_rst_gnt0", 32'(gnt0), 32'd1);
        check("post_rst_gnt1", 32'(gnt1), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
